// File: rtl/multibyte_add_seq.sv
// multibyte_add_seq: byte-serial multi-byte add/subtract controller around an external 8-bit ripple adder.
// Ports: clk, rst (async, active-high); start/sub/op_a/op_b request an op; busy/done/result/carry_out/overflow report it;
//        add_a/add_b/add_cin drive the external adder, add_s/add_cout return its sum and carry.
module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sub,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] result,
  output logic                carry_out,
  output logic                overflow,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  output logic                add_cin,
  input  logic [7:0]          add_s,
  input  logic                add_cout
);
  localparam int W = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]    state;
  logic [W-1:0]  a_reg, b_reg;
  logic          cy_reg;
  logic [IW-1:0] idx;
  logic          run, last;
  assign run = state == RUN;
  assign last = idx == IW'(NBYTES - 1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign add_a = run ? a_reg[{idx, 3'b000} +: 8] : 8'd0;
  assign add_b = run ? b_reg[{idx, 3'b000} +: 8] : 8'd0;
  assign add_cin = run & cy_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      cy_reg <= 1'b0;
      idx <= '0;
      result <= '0;
      carry_out <= 1'b0;
      overflow <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        // subtraction is A + ~B + 1: invert B here, the +1 enters as the first carry-in
        a_reg <= op_a;
        b_reg <= sub ? ~op_b : op_b;
        cy_reg <= sub;
        idx <= '0;
        state <= RUN;
      end
    end else if (run) begin
      result[{idx, 3'b000} +: 8] <= add_s;
      cy_reg <= add_cout;
      idx <= idx + IW'(1);
      if (last) begin
        // b_reg already holds ~B for subtraction, so one rule covers both ops
        carry_out <= add_cout;
        overflow <= (a_reg[W-1] == b_reg[W-1]) && (add_s[7] != a_reg[W-1]);
        state <= DONE;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_multibyte_add_seq.sv
// tb_multibyte_add_seq: table, random and hand-sequenced checks of multibyte_add_seq with a behavioural 8-bit adder.
module tb_multibyte_add_seq;
  localparam int N = 4;
  localparam int W = 8 * N;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sub = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0, result;
  logic busy, done, carry_out, overflow, add_cin, add_cout;
  logic [7:0] add_a, add_b, add_s;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + 9'(add_cin);
  multibyte_add_seq #(.NBYTES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out), .overflow(overflow),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout)
  );
  typedef struct {
    logic [W-1:0] a, b;
    logic         s;
    logic [W-1:0] r;
    logic         c, v;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint t = s ? sa - sb : sa + sb;
    longint lim = longint'(1) <<< (W - 1);
    logic [W-1:0] r = s ? a - b : a + b;
    logic c = s ? (a >= b) : (((longint'(a) + longint'(b)) >>> W) != 0);
    logic v = (t > lim - 1) || (t < -lim);
    return {v, c, r};
  endfunction
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    op_a = a;
    op_b = b;
    sub = s;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask
  task automatic run_chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W-1:0] r, input logic c, input logic v);
    int k;
    start_op(a, b, s);
    wait_done(k);
    chk({nm, "_latency"}, 64'(k), 64'(N + 1));
    chk({nm, "_result"}, 64'(result), 64'(r));
    chk({nm, "_carry"}, 64'(carry_out), 64'(c));
    chk({nm, "_ovf"}, 64'(overflow), 64'(v));
  endtask
  initial begin
    int k, m, pulses;
    logic [W-1:0] a, b;
    logic s;
    logic [W+1:0] e;
    tbl[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[4] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[5] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    #2;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_adder_if", 64'({add_a, add_b, add_cin}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) run_chk($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].r, tbl[i].c, tbl[i].v);
    @(negedge clk);
    chk("idle_adder_if", 64'({add_a, add_b, add_cin}), 64'd0);
    for (int i = 0; i < 25; i++) begin
      a = $urandom;
      b = (i % 5 == 0) ? a : $urandom;
      s = 1'($urandom);
      e = model(a, b, s);
      run_chk($sformatf("rand%0d", i), a, b, s, e[W-1:0], e[W], e[W+1]);
    end
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_flags", 64'({carry_out, overflow}), 64'd0);
    chk("midrst_adder_if", 64'({add_a, add_b, add_cin}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_chk("after_rst", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    e = model(32'hA5A5_0F0F, 32'h0101_F0F1, 1'b1);
    start_op(32'hA5A5_0F0F, 32'h0101_F0F1, 1'b1);
    k = 0;
    pulses = 0;
    while (pulses == 0 && k < 20) begin
      @(negedge clk);
      k++;
      if (k == 2) begin
        start = 1'b1;
        op_a = 32'hDEAD_BEEF;
        op_b = 32'h0;
        sub = 1'b0;
      end
      if (done) pulses++;
    end
    chk("ignore_latency", 64'(k), 64'(N + 1));
    chk("ignore_result", 64'(result), 64'(e[W-1:0]));
    chk("ignore_flags", 64'({overflow, carry_out}), 64'(e[W+1:W]));
    @(negedge clk);
    start = 1'b0;
    chk("ignore_busy_after_done", 64'(busy), 64'd0);
    @(negedge clk);
    op_a = 32'h0000_1000;
    op_b = 32'h0000_0234;
    sub = 1'b0;
    start = 1'b1;
    wait_done(k);
    chk("held_first_done", 64'(done), 64'd1);
    m = 0;
    do begin
      @(negedge clk);
      m++;
    end while (!done && m < 20);
    chk("held_spacing", 64'(m), 64'(N + 2));
    chk("held_result", 64'(result), 64'h0000_1234);
    start = 1'b0;
    @(negedge clk);
    chk("held_release_busy", 64'(busy), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
